// File: rtl/fmul_issue_ctrl_if.sv
// Bus bundle for fmul_issue_ctrl: requester operand handshakes, multiplier
// operand/result taps, response handshake, drain control and sticky flags.
// The controller connects through the slave modport; the surrounding system
// (requesters, multiplier, response consumer) sees the master modport.
interface fmul_issue_ctrl_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        hold;
  logic        idle;
  logic [15:0] mul_op_a;
  logic [15:0] mul_op_b;
  logic        mul_sign;
  logic [4:0]  mul_exponent;
  logic [9:0]  mul_mantissa;
  logic        mul_overflow;
  logic        mul_underflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_underflow;
  logic        sticky_overflow;
  logic        sticky_underflow;
  logic        flag_clear;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  hold, mul_sign, mul_exponent, mul_mantissa, mul_overflow,
    input  mul_underflow, rsp_ready, flag_clear,
    output req0_ready, req1_ready, idle, mul_op_a, mul_op_b,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow,
    output sticky_overflow, sticky_underflow
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output hold, mul_sign, mul_exponent, mul_mantissa, mul_overflow,
    output mul_underflow, rsp_ready, flag_clear,
    input  req0_ready, req1_ready, idle, mul_op_a, mul_op_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow,
    input  sticky_overflow, sticky_underflow
  );
endinterface

// File: rtl/fmul_issue_ctrl.sv
// fmul_issue_ctrl: two-requester round-robin issue controller for the
// half-precision pipelined multiplier. Issues operands, re-aligns the
// multiplier's stage-0 sign/exponent with its stage-1 mantissa/flags and
// queues results (tagged with requester ID) in a 2-entry response FIFO.
// Packing: [15] sign, [14:10] exponent, [9:0] mantissa.
// Optional feature macro: FMUL_ISSUE_CTRL_STICKY_FLAGS_EN (sticky flags).
module fmul_issue_ctrl (
  input  logic             clk,
  input  logic             reset,
  fmul_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  typedef struct packed {
    logic        id;
    logic        ovf;
    logic        unf;
    logic [15:0] result;
  } entry_t;

  function automatic logic [15:0] pack_result(input logic s,
                                              input logic [4:0] e,
                                              input logic [9:0] m);
    return {s, e, m};
  endfunction

  state_t      state;
  logic        idle_q;
  logic        ptr;

  logic        vld_p1;
  logic        id_p1;
  logic        sign_p1;
  logic [4:0]  exp_p1;

  entry_t      fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;

  logic        rsp_v;
  logic        pop;
  logic        push;
  logic [2:0]  occ;
  logic        issue_ok;
  logic        gnt0;
  logic        gnt1;
  entry_t      head;
  entry_t      push_entry;

  // Occupancy counts results already committed (S1 + FIFO) net of this
  // cycle's pop; a new issue needs a free slot two cycles out.
  assign rsp_v    = (fifo_count != 2'd0);
  assign pop      = rsp_v & bus.rsp_ready;
  assign push     = vld_p1;
  assign occ      = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue_ok = reset & (state == ST_RUN) & (occ < 3'd2);

  assign gnt0 = issue_ok & bus.req0_valid & (~bus.req1_valid | ~ptr);
  assign gnt1 = issue_ok & bus.req1_valid & (~bus.req0_valid |  ptr);

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.mul_op_a   = gnt0 ? bus.req0_a : (gnt1 ? bus.req1_a : 16'd0);
  assign bus.mul_op_b   = gnt0 ? bus.req0_b : (gnt1 ? bus.req1_b : 16'd0);

  // Stage-1 multiplier outputs meet the stage-0 capture made a cycle earlier.
  assign push_entry.id     = id_p1;
  assign push_entry.ovf    = bus.mul_overflow;
  assign push_entry.unf    = bus.mul_underflow;
  assign push_entry.result = pack_result(sign_p1, exp_p1, bus.mul_mantissa);

  // Outputs read as zero when empty so storage needs no reset.
  assign head              = fifo_mem[rd_ptr];
  assign bus.rsp_valid     = rsp_v;
  assign bus.rsp_id        = rsp_v & head.id;
  assign bus.rsp_result    = rsp_v ? head.result : 16'd0;
  assign bus.rsp_overflow  = rsp_v & head.ovf;
  assign bus.rsp_underflow = rsp_v & head.unf;
  assign bus.idle          = idle_q;

  // ---- stage 0 -> stage 1 boundary ----
  // Round-robin pointer and S1 valid: pointer moves to the index not granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr    <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= gnt0 | gnt1;
      if (gnt0)      ptr <= 1'b1;
      else if (gnt1) ptr <= 1'b0;
    end
  end

  // S1 data: capture stage-0 sign/exponent and requester ID on issue.
  always_ff @(posedge clk) begin
    if (gnt0 | gnt1) begin
      id_p1   <= gnt1;
      sign_p1 <= bus.mul_sign;
      exp_p1  <= bus.mul_exponent;
    end
  end

  // ---- stage 1 -> response FIFO boundary ----
  // FIFO pointers and count; push and pop may coincide at any count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  // Run/drain/halt state machine with registered idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_RUN;
      idle_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.hold) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.hold) begin
            state <= ST_RUN;
          end else if (!vld_p1 && (fifo_count == 2'd0)) begin
            state  <= ST_HALTED;
            idle_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!bus.hold) begin
            state  <= ST_RUN;
            idle_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          idle_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FMUL_ISSUE_CTRL_STICKY_FLAGS_EN
  logic sticky_ovf;
  logic sticky_unf;

  // Sticky flags: set on push of a flagged entry; a set beats a clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      sticky_ovf <= (push & bus.mul_overflow)  | (sticky_ovf & ~bus.flag_clear);
      sticky_unf <= (push & bus.mul_underflow) | (sticky_unf & ~bus.flag_clear);
    end
  end

  assign bus.sticky_overflow  = sticky_ovf;
  assign bus.sticky_underflow = sticky_unf;
`else
  logic unused_flag_clear;

  assign unused_flag_clear    = bus.flag_clear;
  assign bus.sticky_overflow  = 1'b0;
  assign bus.sticky_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Testbench for fmul_issue_ctrl. Contains a behavioural half-precision
// multiplier (stage-0 sign/exponent combinational, stage-1 mantissa/flags
// registered) and a transaction-level reference model: a queue of
// outstanding results, each becoming visible two cycles after its issue.
module tb_fmul_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fmul_issue_ctrl_if ifc();

  fmul_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // {overflow, underflow, packed result}; truncating, flush-to-zero.
  function automatic logic [17:0] fmul16(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    int          e;
    logic [21:0] p;
    logic [9:0]  m;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {2'b00, s, 15'd0};
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = p[20:11];
      e = e + 1;
    end else begin
      m = p[19:10];
    end
    if (e >= 31) return {2'b10, s, 5'd31, 10'd0};
    if (e <= 0)  return {2'b01, s, 15'd0};
    return {2'b00, s, e[4:0], m};
  endfunction

  // Multiplier model driven from the controller's operand ports.
  logic [17:0] m0;
  assign m0               = fmul16(ifc.mul_op_a, ifc.mul_op_b);
  assign ifc.mul_sign     = m0[15];
  assign ifc.mul_exponent = m0[14:10];
  always @(posedge clk) begin
    ifc.mul_mantissa  <= m0[9:0];
    ifc.mul_overflow  <= m0[17];
    ifc.mul_underflow <= m0[16];
  end

  typedef struct {
    logic        id;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    int          avail;
  } ent_t;

  ent_t q[$];
  logic m_ptr;
  int   m_mode;   // 0 run, 1 drain, 2 halted
  logic m_so, m_su;
  int   cyc;
  logic e_g0, e_g1, e_pop;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] t;
    t = 16'($urandom);
    t[14:10] = 5'($urandom_range(1, 30));
    if ($urandom_range(0, 19) == 0) t[14:10] = 5'd0;
    return t;
  endfunction

  task automatic rand_ops();
    ifc.req0_a = rand_op();
    ifc.req0_b = rand_op();
    ifc.req1_a = rand_op();
    ifc.req1_b = rand_op();
  endtask

  task automatic set_req(input logic v0, input logic v1);
    ifc.req0_valid = v0;
    ifc.req1_valid = v1;
  endtask

  // Compute this cycle's expectations from the model and compare.
  task automatic settle_check();
    logic        head_av;
    logic        ok;
    logic [15:0] ea, eb;
    #2;
    head_av = 1'b0;
    if (q.size() > 0) head_av = (q[0].avail <= cyc);
    e_pop = head_av && ifc.rsp_ready;
    ok    = reset && (m_mode == 0) && ((q.size() - (e_pop ? 1 : 0)) < 2);
    e_g0  = ok && ifc.req0_valid && (!ifc.req1_valid || m_ptr == 1'b0);
    e_g1  = ok && ifc.req1_valid && (!ifc.req0_valid || m_ptr == 1'b1);
    ea    = e_g0 ? ifc.req0_a : (e_g1 ? ifc.req1_a : 16'd0);
    eb    = e_g0 ? ifc.req0_b : (e_g1 ? ifc.req1_b : 16'd0);
    chk("req0_ready", 32'(ifc.req0_ready), 32'(e_g0));
    chk("req1_ready", 32'(ifc.req1_ready), 32'(e_g1));
    chk("mul_op_a", 32'(ifc.mul_op_a), 32'(ea));
    chk("mul_op_b", 32'(ifc.mul_op_b), 32'(eb));
    chk("rsp_valid", 32'(ifc.rsp_valid), 32'(head_av));
    chk("rsp_id", 32'(ifc.rsp_id), head_av ? 32'(q[0].id) : 32'd0);
    chk("rsp_result", 32'(ifc.rsp_result), head_av ? 32'(q[0].res) : 32'd0);
    chk("rsp_overflow", 32'(ifc.rsp_overflow), head_av ? 32'(q[0].ovf) : 32'd0);
    chk("rsp_underflow", 32'(ifc.rsp_underflow), head_av ? 32'(q[0].unf) : 32'd0);
    chk("idle", 32'(ifc.idle), 32'(m_mode == 2));
    chk("sticky_overflow", 32'(ifc.sticky_overflow), 32'(m_so));
    chk("sticky_underflow", 32'(ifc.sticky_underflow), 32'(m_su));
  endtask

  // Advance one clock and update the model by the transaction rules.
  task automatic tick();
    int          busy;
    logic [17:0] r;
    ent_t        e;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_ptr  = 1'b0;
      m_mode = 0;
      m_so   = 1'b0;
      m_su   = 1'b0;
    end else begin
      busy = q.size();
`ifdef FMUL_ISSUE_CTRL_STICKY_FLAGS_EN
      begin
        logic so, su;
        so = 1'b0;
        su = 1'b0;
        foreach (q[i]) if (q[i].avail == cyc + 1) begin
          so = q[i].ovf;
          su = q[i].unf;
        end
        m_so = so | (m_so & !ifc.flag_clear);
        m_su = su | (m_su & !ifc.flag_clear);
      end
`endif
      if (e_pop) void'(q.pop_front());
      if (e_g0 || e_g1) begin
        r       = e_g0 ? fmul16(ifc.req0_a, ifc.req0_b) : fmul16(ifc.req1_a, ifc.req1_b);
        e.id    = e_g1;
        e.res   = r[15:0];
        e.ovf   = r[17];
        e.unf   = r[16];
        e.avail = cyc + 2;
        q.push_back(e);
        m_ptr = e_g0;
      end
      case (m_mode)
        0: if (ifc.hold) m_mode = 1;
        1: if (!ifc.hold) m_mode = 0; else if (busy == 0) m_mode = 2;
        default: if (!ifc.hold) m_mode = 0;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    settle_check();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int grants;
    int idle_at;
    reset          = 1'b0;
    set_req(1'b0, 1'b0);
    ifc.req0_a     = 16'd0;
    ifc.req0_b     = 16'd0;
    ifc.req1_a     = 16'd0;
    ifc.req1_b     = 16'd0;
    ifc.hold       = 1'b0;
    ifc.rsp_ready  = 1'b0;
    ifc.flag_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    m_ptr = 1'b0; m_mode = 0; m_so = 1'b0; m_su = 1'b0; cyc = 0;

    // Reset values.
    step();
    reset = 1'b1;

    // Single request: 1.0 x 2.0, response two cycles after the grant.
    ifc.req0_a = 16'h3C00;
    ifc.req0_b = 16'h4000;
    ifc.rsp_ready = 1'b1;
    set_req(1'b1, 1'b0);
    settle_check();
    chk("t1_grant", 32'(ifc.req0_ready), 32'd1);
    tick();
    set_req(1'b0, 1'b0);
    settle_check();
    chk("t1_not_yet", 32'(ifc.rsp_valid), 32'd0);
    tick();
    settle_check();
    chk("t1_valid", 32'(ifc.rsp_valid), 32'd1);
    chk("t1_result", 32'(ifc.rsp_result), 32'h4000);
    chk("t1_id", 32'(ifc.rsp_id), 32'd0);
    tick();

    // Reset returns the pointer to requester 0.
    reset = 1'b0;
    step();
    reset = 1'b1;

    // Both valid for 6 cycles: alternating grants, back-to-back responses.
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        set_req(1'b1, 1'b1);
        rand_ops();
      end else begin
        set_req(1'b0, 1'b0);
      end
      settle_check();
      if (i < 6) begin
        chk("t2_g0", 32'(ifc.req0_ready), 32'(i % 2 == 0));
        chk("t2_g1", 32'(ifc.req1_ready), 32'(i % 2 == 1));
      end
      if (i >= 2) begin
        chk("t2_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
        chk("t2_rsp_id", 32'(ifc.rsp_id), 32'((i - 2) % 2));
      end
      tick();
    end
    repeat (2) step();

    // Backpressure: exactly two grants, then resume on rsp_ready.
    ifc.rsp_ready = 1'b0;
    set_req(1'b1, 1'b1);
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      settle_check();
      grants += int'(ifc.req0_ready) + int'(ifc.req1_ready);
      tick();
    end
    chk("t3_grants", 32'(grants), 32'd2);
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step();
    end
    set_req(1'b0, 1'b0);
    repeat (3) step();

    // Hold with two results queued, drain to idle, then resume.
    ifc.rsp_ready = 1'b0;
    set_req(1'b1, 1'b1);
    rand_ops();
    repeat (4) step();
    ifc.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle_check();
      chk("t4_nogrant", 32'(ifc.req0_ready | ifc.req1_ready), 32'd0);
      tick();
    end
    ifc.rsp_ready = 1'b1;
    idle_at = -1;
    for (int k = 0; k < 8; k++) begin
      settle_check();
      if (idle_at < 0 && ifc.idle === 1'b1) idle_at = k;
      tick();
    end
    chk("t4_idle_at", 32'(idle_at), 32'd3);
    ifc.hold = 1'b0;
    settle_check();
    chk("t4_halt_nogrant", 32'(ifc.req0_ready | ifc.req1_ready), 32'd0);
    tick();
    settle_check();
    chk("t4_resume", 32'(ifc.req0_ready | ifc.req1_ready), 32'd1);
    tick();
    set_req(1'b0, 1'b0);
    repeat (4) step();

    // Overflow and sticky flag.
    ifc.req1_a = 16'h7BFF;
    ifc.req1_b = 16'h7BFF;
    set_req(1'b0, 1'b1);
    step();
    set_req(1'b0, 1'b0);
    step();
    settle_check();
    chk("t5_valid", 32'(ifc.rsp_valid), 32'd1);
    chk("t5_overflow", 32'(ifc.rsp_overflow), 32'd1);
    chk("t5_result", 32'(ifc.rsp_result), 32'h7C00);
    tick();
    repeat (2) step();
    settle_check();
`ifdef FMUL_ISSUE_CTRL_STICKY_FLAGS_EN
    chk("t5_sticky_held", 32'(ifc.sticky_overflow), 32'd1);
`else
    chk("t5_sticky_off", 32'(ifc.sticky_overflow), 32'd0);
`endif
    tick();
    ifc.flag_clear = 1'b1;
    step();
    ifc.flag_clear = 1'b0;
    settle_check();
    chk("t5_sticky_clear", 32'(ifc.sticky_overflow), 32'd0);
    tick();

    // Reset with a full FIFO discards everything.
    ifc.rsp_ready = 1'b0;
    set_req(1'b1, 1'b1);
    rand_ops();
    repeat (4) step();
    set_req(1'b0, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    settle_check();
    chk("t6_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("t6_rsp_result", 32'(ifc.rsp_result), 32'd0);
    tick();
    set_req(1'b1, 1'b1);
    settle_check();
    chk("t6_first_grant", 32'(ifc.req0_ready), 32'd1);
    tick();
    set_req(1'b0, 1'b0);
    ifc.rsp_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      set_req(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6));
      rand_ops();
      ifc.rsp_ready  = 1'($urandom_range(0, 9) < 7);
      ifc.flag_clear = 1'($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) ifc.hold = ~ifc.hold;
      reset = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1;
    ifc.hold = 1'b0;
    ifc.flag_clear = 1'b0;
    ifc.rsp_ready = 1'b1;
    set_req(1'b0, 1'b0);
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
